lsu: RTL and testbench
======================

# lsu

Load/store unit: the initiator side of the core's byte-addressable data-memory port. Accepts one load or store request at a time from the execute/memory stage over a valid/ready handshake, drives the data-memory address/write-data/write-enable/control port, and returns a single-cycle response with the sign- or zero-extended load result. Misaligned halfword/word accesses are split into sequential byte beats, or faulted, depending on a parameter.

## Interface
- SPLIT_MISALIGNED, 1, 1: split misaligned half/word into byte beats; 0: fault them with no memory access
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&&ready
- req_we  in  1  1 = store, 0 = load
- req_ctl  in  3  000 bu, 001 hu, 010 w, 100 b, 101 h; 011/110/111 invalid
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- rsp_valid  out  1  one-cycle response strobe, no backpressure
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- rsp_fault  out  1  invalid ctl, or misaligned with SPLIT_MISALIGNED=0
- mem_a  out  32  memory address
- mem_wd  out  32  memory write data
- mem_we  out  1  memory write enable
- mem_ctl  out  3  memory size control, same encoding
- mem_rd  in  32  memory read data, valid the cycle after the address is presented

## Operation
- States: IDLE, ISSUE, DRAIN, RESP. req_ready = (state==IDLE).
- IDLE: on accept, latch we/ctl/addr/wdata, compute beat count n. Invalid ctl, or misaligned with SPLIT_MISALIGNED=0 → RESP with fault. Otherwise → ISSUE, beat 0.
- Misaligned: ctl[1:0]=01 with addr[0]=1; ctl[1:0]=10 with addr[1:0]≠0. Bytes are never misaligned.
- n = 1 for aligned; n = 2 (half) or 4 (word) for split.
- ISSUE beat i, aligned: mem_a=addr, mem_ctl={1'b0,ctl[1:0]}, mem_wd=wdata, mem_we=we.
- ISSUE beat i, split: mem_a=addr+i (mod 2^32), mem_ctl=000, mem_wd[7:0]=wdata byte i, upper bits 0, mem_we=we.
- Loads are always issued unsigned; the LSU performs all sign extension itself.
- Load capture: in ISSUE beat i>0 and in DRAIN, mem_rd holds beat i−1. Split beats deposit mem_rd[7:0] into assembly byte i−1. Aligned loads take the full mem_rd in DRAIN.
- After the last ISSUE beat: stores → RESP; loads → DRAIN → RESP.
- RESP: rsp_valid=1 for one cycle, then → IDLE.
- Load result by ctl size:
  - Byte: bits [7:0], extended with ctl[2]&bit7.
  - Half: bits [15:0], extended with ctl[2]&bit15.
  - Word: unchanged.
- Outside ISSUE: mem_we=0, mem_a=0, mem_wd=0, mem_ctl=010.

## Timing
- Accept at edge ending cycle T.
- Aligned load: ISSUE T+1, DRAIN T+2, rsp_valid T+3.
- Aligned store: ISSUE T+1, rsp_valid T+2; memory written at edge ending T+1.
- Split load: ISSUE T+1..T+n, DRAIN T+n+1, rsp_valid T+n+2.
- Split store: rsp_valid T+n+1.
- Fault: rsp_valid T+1, no mem_we at any point.
- Next accept no earlier than the cycle after RESP. Aligned load throughput is 1 per 4 cycles.
- All mem_* outputs and rsp_* outputs are registered or decoded from state only. There is no combinational path from req_* to mem_*.
- Reset values: state IDLE (req_ready=1 after release), rsp_valid 0, rsp_rdata 0, rsp_fault 0, mem_we 0, mem_a 0, mem_wd 0, mem_ctl 010.
- Reset mid-operation: mem_we drops immediately, remaining beats are abandoned, no response is generated. Bytes already written stay written.

## Structure
- Package lsu_pkg:
  - ctl encodings: CTL_BU, CTL_HU, CTL_W, CTL_B, CTL_H
  - state enum
  - idle mem_ctl constant (CTL_W)
- One sub-module, ld_ext: combinational size select and sign/zero extension of the 32-bit assembled word by ctl.

## Test plan
- Aligned lw, mem[0x100..0x103]=EF,BE,AD,DE → single beat, mem_ctl=010; rsp_valid at T+3 with rsp_rdata=0xDEADBEEF, fault 0.
- lb and lbu at 0x103 holding 0x80 → rsp_rdata 0xFFFFFF80 and 0x00000080 respectively; mem_ctl=000 in both cases.
- Misaligned sw 0x12345678 at 0x101 → four beats, mem_a 0x101..0x104, mem_wd[7:0] 78,56,34,12, mem_ctl=000, rsp at T+5. Following lw at 0x101 returns 0x12345678 at T+6 after its accept.
- lh at 0x1FF, bytes 0x34/0x92 → two beats, rsp_rdata 0xFFFF9234 at T+4. With SPLIT_MISALIGNED=0 → rsp_fault=1, rdata 0, rsp at T+1, mem_we never asserted.
- req_ctl=011 → rsp_fault=1 at T+1, no memory beat, req_ready back to 1 at T+2.
- rst asserted during beat 2 of a split sw → mem_we=0 the same cycle, no rsp_valid, beat-3 byte unchanged, req_ready=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - size/sign control encodings used on both the request and memory ports
//   - controller state enum
//   - helpers that classify a request's control code and alignment
package lsu_pkg;

    localparam logic [2:0] CTL_BU = 3'b000;
    localparam logic [2:0] CTL_HU = 3'b001;
    localparam logic [2:0] CTL_W  = 3'b010;
    localparam logic [2:0] CTL_B  = 3'b100;
    localparam logic [2:0] CTL_H  = 3'b101;

    // mem_ctl value whenever no beat is being issued
    localparam logic [2:0] MEM_CTL_IDLE = CTL_W;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StResp
    } lsu_state_e;

    function automatic logic ctl_is_valid(input logic [2:0] ctl);
        return (ctl == CTL_BU) || (ctl == CTL_HU) || (ctl == CTL_W) ||
               (ctl == CTL_B)  || (ctl == CTL_H);
    endfunction

    // Bytes are never misaligned; only meaningful for valid ctl codes.
    function automatic logic is_misaligned(input logic [2:0] ctl, input logic [1:0] addr_lo);
        return ((ctl[1:0] == 2'b01) && addr_lo[0]) ||
               ((ctl[1:0] == 2'b10) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/ld_ext.sv
// Load-result extension.
// Selects byte/half/word from an LSB-aligned assembled word according to ctl and
// sign-extends (ctl[2]=1) or zero-extends (ctl[2]=0) it to 32 bits.
//   ctl    in  3   size/sign control
//   data   in  32  assembled load word, LSB-aligned
//   result out 32  extended load result
module ld_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  ctl,
    input  logic [31:0] data,
    output logic [31:0] result
);

    always_comb begin
        result = data;
        case (ctl[1:0])
            2'b00:   result = {{24{ctl[2] & data[7]}}, data[7:0]};
            2'b01:   result = {{16{ctl[2] & data[15]}}, data[15:0]};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: initiator side of the byte-addressable data-memory port.
// Takes one request at a time, issues one aligned beat or a sequence of byte beats
// for misaligned half/word accesses (or faults them when SPLIT_MISALIGNED=0), and
// returns a one-cycle response with the extended load data.
//   clk, rst                      clock, async active-high reset
//   req_valid/req_ready           request handshake (ready only in idle)
//   req_we/req_ctl/req_addr/req_wdata  request fields
//   rsp_valid/rsp_rdata/rsp_fault     one-cycle response strobe and payload
//   mem_a/mem_wd/mem_we/mem_ctl       memory command, decoded from registers only
//   mem_rd                        memory read data, one cycle after the address
module lsu
    import lsu_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_ctl,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    output logic [2:0]  mem_ctl,
    input  logic [31:0] mem_rd
);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  ctl_q, ctl_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        split_q, split_d;
    logic        fault_q, fault_d;
    logic [1:0]  beat_q, beat_d;
    logic [1:0]  last_q, last_d;   // index of the final beat (n-1)
    logic [31:0] asm_q, asm_d;     // load assembly register
    logic [1:0]  prev_idx;
    logic        req_mis;
    logic [31:0] ext_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            ctl_q   <= MEM_CTL_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            split_q <= 1'b0;
            fault_q <= 1'b0;
            beat_q  <= '0;
            last_q  <= '0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            ctl_q   <= ctl_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            split_q <= split_d;
            fault_q <= fault_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            asm_q   <= asm_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        ctl_d    = ctl_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        split_d  = split_q;
        fault_d  = fault_q;
        beat_d   = beat_q;
        last_d   = last_q;
        asm_d    = asm_q;
        prev_idx = beat_q - 2'd1;
        req_mis  = ctl_is_valid(req_ctl) && is_misaligned(req_ctl, req_addr[1:0]);

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d    = req_we;
                    ctl_d   = req_ctl;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    asm_d   = '0;
                    beat_d  = '0;
                    fault_d = !ctl_is_valid(req_ctl) || (req_mis && !SPLIT_MISALIGNED);
                    split_d = req_mis && SPLIT_MISALIGNED;
                    if (split_d) begin
                        last_d = (req_ctl[1:0] == 2'b01) ? 2'd1 : 2'd3;
                    end else begin
                        last_d = 2'd0;
                    end
                    state_d = fault_d ? StResp : StIssue;
                end
            end
            StIssue: begin
                // mem_rd now carries the byte fetched by the previous beat
                if (!we_q && split_q && (beat_q != 2'd0)) begin
                    asm_d[{prev_idx, 3'b000} +: 8] = mem_rd[7:0];
                end
                if (beat_q == last_q) begin
                    state_d = we_q ? StResp : StDrain;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            StDrain: begin
                if (split_q) begin
                    asm_d[{last_q, 3'b000} +: 8] = mem_rd[7:0];
                end else begin
                    asm_d = mem_rd;
                end
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    ld_ext u_ld_ext (
        .ctl    (ctl_q),
        .data   (asm_q),
        .result (ext_data)
    );

    // Memory command: decoded purely from registered state, so reset drops mem_we at once.
    always_comb begin
        mem_we  = 1'b0;
        mem_a   = '0;
        mem_wd  = '0;
        mem_ctl = MEM_CTL_IDLE;
        if (state_q == StIssue) begin
            mem_we = we_q;
            if (split_q) begin
                mem_a   = addr_q + {30'd0, beat_q};
                mem_ctl = CTL_BU;
                mem_wd  = {24'd0, wdata_q[{beat_q, 3'b000} +: 8]};
            end else begin
                mem_a   = addr_q;
                mem_ctl = {1'b0, ctl_q[1:0]};   // always fetch unsigned
                mem_wd  = wdata_q;
            end
        end
    end

    always_comb begin
        req_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
        rsp_fault = rsp_valid && fault_q;
        rsp_rdata = (rsp_valid && !we_q && !fault_q) ? ext_data : '0;
    end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_ctl = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [2:0]  mem_ctl;
    logic [31:0] mem_rd = '0;

    // second instance with splitting disabled, sharing the request inputs
    logic        ns_req_ready, ns_rsp_valid, ns_rsp_fault, ns_mem_we;
    logic [31:0] ns_rsp_rdata, ns_mem_a, ns_mem_wd;
    logic [2:0]  ns_mem_ctl;

    always #5 clk = ~clk;

    lsu #(.SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_ctl(req_ctl), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_we(mem_we), .mem_ctl(mem_ctl), .mem_rd(mem_rd)
    );

    lsu #(.SPLIT_MISALIGNED(1'b0)) dut_ns (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ns_req_ready), .req_we(req_we),
        .req_ctl(req_ctl), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(ns_rsp_valid), .rsp_rdata(ns_rsp_rdata), .rsp_fault(ns_rsp_fault),
        .mem_a(ns_mem_a), .mem_wd(ns_mem_wd), .mem_we(ns_mem_we), .mem_ctl(ns_mem_ctl),
        .mem_rd(32'h0)
    );

    int n_pass = 0;
    int n_total = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endfunction

    function automatic int midx(input logic [31:0] a, input int i);
        logic [31:0] s;
        s = a + 32'(i);
        return int'(s[9:0]);
    endfunction

    // Memory environment (1 KiB window) and the model's own view of memory.
    logic [7:0] mem [1024];
    logic [7:0] ref_mem [1024];

    always @(posedge clk) begin
        logic [31:0] rd;
        int sz;
        sz = (mem_ctl[1:0] == 2'b00) ? 1 : (mem_ctl[1:0] == 2'b01) ? 2 : 4;
        rd = '0;
        for (int i = 0; i < 4; i++)
            if (i < sz) rd = rd | (32'(mem[midx(mem_a, i)]) << (8 * i));
        mem_rd <= rd;
        if (mem_we)
            for (int i = 0; i < 4; i++)
                if (i < sz) mem[midx(mem_a, i)] <= mem_wd[8*i +: 8];
    end

    // ---------------- transaction-level reference model ----------------
    logic        e_we, e_mis, e_fault;
    logic [2:0]  e_ctl;
    logic [31:0] e_addr, e_wdata, e_rdata;
    int          e_nb, e_lat;

    function automatic void model_accept(input logic we, input logic [2:0] ctl,
                                         input logic [31:0] addr, input logic [31:0] wd);
        int sz;
        logic ok;
        logic [31:0] v;
        ok = (ctl == 3'd0) || (ctl == 3'd1) || (ctl == 3'd2) || (ctl == 3'd4) || (ctl == 3'd5);
        sz = (ctl[1:0] == 2'b00) ? 1 : (ctl[1:0] == 2'b01) ? 2 : 4;
        e_we = we; e_ctl = ctl; e_addr = addr; e_wdata = wd;
        e_mis = ok && ((sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00));
        e_fault = !ok;
        e_rdata = '0;
        if (!ok) begin
            e_nb = 0;
            e_lat = 1;
        end else begin
            e_nb = e_mis ? sz : 1;
            e_lat = we ? e_nb + 1 : e_nb + 2;
            if (we) begin
                for (int i = 0; i < sz; i++) ref_mem[midx(addr, i)] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[midx(addr, i)]) << (8 * i));
                if (ctl[2] && sz == 1 && v[7])  v = v | 32'hFFFF_FF00;
                if (ctl[2] && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
                e_rdata = v;
            end
        end
    endfunction

    // ---------------- per-cycle compare process ----------------
    logic        tr_busy = 1'b0;
    int          k = 0;
    int          last_lat = 0;
    logic [31:0] last_rdata = '0;
    logic        last_fault = 1'b0;
    logic [2:0]  first_ctl = '0;
    int          obs_n = 0;
    logic [31:0] obs_a [8];
    logic [31:0] obs_wd [8];
    logic [2:0]  obs_ctl_or = '0;
    logic [31:0] exp_a, exp_wd;
    logic [2:0]  exp_ctl;

    always @(negedge clk) begin
        if (rst) begin
            tr_busy = 1'b0;
        end else if (tr_busy) begin
            k++;
            chk("busy_ready", 32'(req_ready), 32'd0);
            chk("rsp_valid_timing", 32'(rsp_valid), 32'(k == e_lat));
            if (k == 1) first_ctl = mem_ctl;
            if (mem_we) begin
                if (obs_n < 8) begin
                    obs_a[obs_n] = mem_a;
                    obs_wd[obs_n] = mem_wd;
                end
                obs_n++;
                obs_ctl_or = obs_ctl_or | mem_ctl;
            end
            if (rsp_valid && last_lat == 0) begin
                last_lat = k;
                last_rdata = rsp_rdata;
                last_fault = rsp_fault;
            end
            if (k <= e_nb) begin
                exp_a   = e_mis ? e_addr + 32'(k - 1) : e_addr;
                exp_ctl = e_mis ? 3'b000 : {1'b0, e_ctl[1:0]};
                exp_wd  = e_mis ? ((e_wdata >> (8 * (k - 1))) & 32'hFF) : e_wdata;
                chk("beat_we", 32'(mem_we), 32'(e_we));
                chk("beat_a", mem_a, exp_a);
                chk("beat_ctl", 32'(mem_ctl), 32'(exp_ctl));
                chk("beat_wd", mem_wd, exp_wd);
            end else begin
                chk("nobeat_we", 32'(mem_we), 32'd0);
                chk("nobeat_a", mem_a, 32'd0);
                chk("nobeat_wd", mem_wd, 32'd0);
                chk("nobeat_ctl", 32'(mem_ctl), 32'd2);
            end
            if (k == e_lat) begin
                chk("rsp_rdata", rsp_rdata, e_rdata);
                chk("rsp_fault", 32'(rsp_fault), 32'(e_fault));
                tr_busy = 1'b0;
            end
        end else begin
            chk("idle_ready", 32'(req_ready), 32'd1);
            chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("idle_mem_we", 32'(mem_we), 32'd0);
            chk("idle_mem_ctl", 32'(mem_ctl), 32'd2);
            if (req_valid) begin
                model_accept(req_we, req_ctl, req_addr, req_wdata);
                tr_busy = 1'b1;
                k = 0;
                last_lat = 0;
                last_rdata = '0;
                last_fault = 1'b0;
                obs_n = 0;
                obs_ctl_or = '0;
            end
        end
    end

    // Observer for the non-splitting instance (used by directed checks only).
    logic        ns_busy = 1'b0, ns_we_seen = 1'b0, ns_fault = 1'b0;
    int          ns_k = 0, ns_lat = 0;
    logic [31:0] ns_rdata = '0;

    always @(negedge clk) begin
        if (rst) begin
            ns_busy = 1'b0;
        end else begin
            if (ns_busy) begin
                ns_k++;
                if (ns_mem_we) ns_we_seen = 1'b1;
                if (ns_rsp_valid && ns_lat == 0) begin
                    ns_lat = ns_k;
                    ns_rdata = ns_rsp_rdata;
                    ns_fault = ns_rsp_fault;
                end
                if (ns_req_ready) ns_busy = 1'b0;
            end
            if (!ns_busy && req_valid && ns_req_ready) begin
                ns_busy = 1'b1;
                ns_k = 0;
                ns_lat = 0;
                ns_we_seen = 1'b0;
                ns_rdata = '0;
                ns_fault = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Caller is positioned just after a rising edge.
    task automatic do_req(input logic we, input logic [2:0] ctl, input logic [31:0] addr,
                          input logic [31:0] wd);
        int g = 0;
        while (!req_ready && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 50) chk("ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we = we;
        req_ctl = ctl;
        req_addr = addr;
        req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = 1'($urandom);
        req_ctl = 3'($urandom);
        req_addr = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic wait_rsp();
        int g = 0;
        while (tr_busy && g < 40) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 40) chk("rsp_timeout", 32'(tr_busy), 32'd0);
    endtask

    logic [2:0] ctl_tab [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

    initial begin
        logic [7:0]  old2, old3, b;
        logic [31:0] a;
        bit          seen;
        int          bad;

        for (int i = 0; i < 1024; i++) begin
            b = 8'($urandom);
            mem[i] = b;
            ref_mem[i] = b;
        end
        mem[12'h100] = 8'hEF; mem[12'h101] = 8'hBE; mem[12'h102] = 8'hAD; mem[12'h103] = 8'hDE;
        mem[12'h1FF] = 8'h34; mem[12'h200] = 8'h92;
        ref_mem[12'h100] = 8'hEF; ref_mem[12'h101] = 8'hBE;
        ref_mem[12'h102] = 8'hAD; ref_mem[12'h103] = 8'hDE;
        ref_mem[12'h1FF] = 8'h34; ref_mem[12'h200] = 8'h92;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_fault", 32'(rsp_fault), 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        chk("reset_mem_a", mem_a, 32'd0);
        chk("reset_mem_wd", mem_wd, 32'd0);
        chk("reset_mem_ctl", 32'(mem_ctl), 32'd2);

        // aligned lw
        do_req(1'b0, 3'b010, 32'h100, 32'h0); wait_rsp();
        chk("lw_lat", 32'(last_lat), 32'd3);
        chk("lw_rdata", last_rdata, 32'hDEAD_BEEF);
        chk("lw_fault", 32'(last_fault), 32'd0);
        chk("lw_ctl", 32'(first_ctl), 32'd2);

        // sb 0x80, then lb / lbu
        do_req(1'b1, 3'b100, 32'h103, 32'h0000_0080); wait_rsp();
        chk("sb_lat", 32'(last_lat), 32'd2);
        do_req(1'b0, 3'b100, 32'h103, 32'h0); wait_rsp();
        chk("lb_rdata", last_rdata, 32'hFFFF_FF80);
        chk("lb_ctl", 32'(first_ctl), 32'd0);
        do_req(1'b0, 3'b000, 32'h103, 32'h0); wait_rsp();
        chk("lbu_rdata", last_rdata, 32'h0000_0080);
        chk("lbu_ctl", 32'(first_ctl), 32'd0);

        // misaligned sw split into four byte beats
        do_req(1'b1, 3'b010, 32'h101, 32'h1234_5678); wait_rsp();
        chk("sw_mis_lat", 32'(last_lat), 32'd5);
        chk("sw_mis_beats", 32'(obs_n), 32'd4);
        chk("sw_mis_a0", obs_a[0], 32'h101);
        chk("sw_mis_a3", obs_a[3], 32'h104);
        chk("sw_mis_bytes", {obs_wd[3][7:0], obs_wd[2][7:0], obs_wd[1][7:0], obs_wd[0][7:0]},
            32'h1234_5678);
        chk("sw_mis_ctl", 32'(obs_ctl_or), 32'd0);
        do_req(1'b0, 3'b010, 32'h101, 32'h0); wait_rsp();
        chk("lw_mis_lat", 32'(last_lat), 32'd6);
        chk("lw_mis_rdata", last_rdata, 32'h1234_5678);

        // lh across 0x1FF/0x200
        do_req(1'b0, 3'b101, 32'h1FF, 32'h0); wait_rsp();
        chk("lh_mis_lat", 32'(last_lat), 32'd4);
        chk("lh_mis_rdata", last_rdata, 32'hFFFF_9234);
        chk("ns_lh_lat", 32'(ns_lat), 32'd1);
        chk("ns_lh_fault", 32'(ns_fault), 32'd1);
        chk("ns_lh_rdata", ns_rdata, 32'd0);
        chk("ns_lh_we", 32'(ns_we_seen), 32'd0);

        do_req(1'b1, 3'b001, 32'h303, 32'h0000_BEEF); wait_rsp();
        chk("ns_sh_fault", 32'(ns_fault), 32'd1);
        chk("ns_sh_we", 32'(ns_we_seen), 32'd0);

        // invalid ctl
        do_req(1'b0, 3'b011, 32'h100, 32'h0); wait_rsp();
        chk("bad_ctl_lat", 32'(last_lat), 32'd1);
        chk("bad_ctl_fault", 32'(last_fault), 32'd1);
        chk("bad_ctl_rdata", last_rdata, 32'd0);
        chk("bad_ctl_beats", 32'(obs_n), 32'd0);
        chk("bad_ctl_ready", 32'(req_ready), 32'd1);

        // reset during beat 2 of a split sw
        old2 = ref_mem[12'h2F3];
        old3 = ref_mem[12'h2F4];
        do_req(1'b1, 3'b010, 32'h2F1, 32'hA1B2_C3D4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_pre_we", 32'(mem_we), 32'd1);
        chk("rst_pre_a", mem_a, 32'h2F3);
        rst = 1'b1;
        #1;
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_release_ready", 32'(req_ready), 32'd1);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("rst_no_rsp", 32'(seen), 32'd0);
        chk("rst_byte0", 32'(mem[12'h2F1]), 32'hD4);
        chk("rst_byte1", 32'(mem[12'h2F2]), 32'hC3);
        chk("rst_byte2", 32'(mem[12'h2F3]), 32'(old2));
        chk("rst_byte3", 32'(mem[12'h2F4]), 32'(old3));
        ref_mem[12'h2F3] = old2;
        ref_mem[12'h2F4] = old3;
        @(posedge clk); #1;

        // randomized back-to-back traffic
        for (int t = 0; t < 400; t++) begin
            a = ($urandom_range(0, 3) == 0) ? $urandom : {22'd0, 10'($urandom)};
            do_req(1'($urandom), ctl_tab[$urandom_range(0, 9)], a, $urandom);
        end
        wait_rsp();

        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("final_mem_image", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
